ram_sp_arbiter: RTL and testbench
=================================

Name: ram_sp_arbiter

Overview:
- Arbitrates a single-port synchronous RAM (ram_sp: chip_select / write_enable / output_enable, bidirectional data bus) between NUM_REQ requesters.
- Each requester has a valid/ready command interface. The block sequences the RAM control pins, owns the tristate bus, and returns read data with a one-cycle response strobe.
- Sits directly in front of one ram_sp instance. It is the only master of that instance.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- DEPTH, 16, RAM words; must match the ram_sp instance.
- DATA_WIDTH, 32, word width.
- ADDR_WIDTH, $clog2(DEPTH), address width (derived).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept (one-hot or zero).
- req_we  in  NUM_REQ  1=write, 0=read, per requester.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- rsp_valid  out  NUM_REQ  one-cycle read-data strobe, per requester.
- rsp_rdata  out  DATA_WIDTH  read data; shared, qualified by rsp_valid.
- ram_addr  out  ADDR_WIDTH  to ram_sp addr.
- ram_data  inout  DATA_WIDTH  to ram_sp data.
- ram_cs  out  1  to ram_sp chip_select.
- ram_we  out  1  to ram_sp write_enable.
- ram_oe  out  1  to ram_sp output_enable.

Behaviour:
- RAM timing contract:
  - Write commits at the posedge where cs=1 and we=1.
  - Read: cs=1, we=0, oe=1 at posedge E registers the word. ram_sp drives it during the following cycle, while oe is still held.
- FSM states: IDLE, WRITE, READ_ADDR, READ_DATA.
- IDLE:
  - Round-robin pick among req_valid, searching from last_grant+1 upward with wrap.
  - req_ready = one-hot of the winner, combinational from req_valid and state; zero in every non-IDLE state.
  - On accept (valid & ready at posedge): latch addr, wdata, we and requester id; update last_grant.
  - Next state: WRITE if we=1, READ_ADDR if we=0.
  - No valid → stay in IDLE.
- WRITE:
  - Outputs: ram_cs=1, ram_we=1, ram_oe=0, ram_addr=latched addr, ram_data driven with latched wdata.
  - Next state: IDLE.
- READ_ADDR:
  - Outputs: ram_cs=1, ram_we=0, ram_oe=1, ram_addr=latched addr, ram_data released (z).
  - Next state: READ_DATA.
- READ_DATA:
  - Outputs: same as READ_ADDR.
  - At the posedge leaving this state: rsp_rdata <= ram_data, rsp_valid[id] <= 1.
  - Next state: IDLE.
- rsp_valid is registered and high for exactly one cycle.
- Read latency: rsp_valid asserts 3 cycles after the accept cycle.
- Throughput: write, one per 2 cycles; read, one per 3 cycles. The accept in IDLE overlaps nothing.
- IDLE pin outputs: cs=0, we=0, oe=0, ram_addr=0, ram_data=z.
- Bus ownership: ram_data is driven only in WRITE, where ram_oe=0. Controller drive and oe=1 are never simultaneous.
- rsp_rdata holds its last captured value between strobes.
- Requester obligations:
  - Hold valid and payload stable until ready.
  - Withdrawing valid before ready is legal; nothing is committed.
- Persistent contention: grants strictly alternate between requesters.
- Reset values: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), rsp_valid=0, rsp_rdata=0, ram_addr=0, cs/we/oe=0, ram_data=z, req_ready=0.
- Reset mid-operation:
  - ram_cs, ram_we, ram_oe and req_ready are gated combinationally by rst_n, so no write commits at a reset edge.
  - An in-flight read is dropped with no rsp_valid.

Decomposition:
- Package ram_arb_pkg: state enum (IDLE, WRITE, READ_ADDR, READ_DATA) and the default width constants.
- Sub-module rr_arbiter #(N):
  - Inputs: request vector, last_grant, enable.
  - Output: one-hot grant.
  - Pure combinational, with rotate-and-priority-encode.
  - last_grant register stays in the top level.

Test Plan:
- Reset test: rst_n=0 for 3 cycles with req_valid=2'b11 → req_ready=0, cs/we/oe=0, rsp_valid=0, ram_data=z throughout.
- Write then read:
  - Step 1: req0 write addr 3, data 0xDEADBEEF → req_ready[0] in the accept cycle; next cycle cs=1, we=1, ram_addr=3, ram_data=0xDEADBEEF.
  - Step 2: req1 read addr 3 → rsp_valid[1] high for exactly one cycle, 3 cycles after accept, with rsp_rdata=0xDEADBEEF; rsp_valid[0] stays 0.
- Contention test: both requesters hold valid with writes (req0 to even addrs, req1 to odd) → grants 0,1,0,1…, one accept every 2 cycles; readback of all addresses matches.
- Fill/readback: req0 writes $random to all 16 addresses, req1 reads 0..15 → 16 rsp_valid[1] pulses with matching data.
- Reset during WRITE (addr 5, 0x12345678 over old 0xAAAAAAAA) → ram_cs=0 on that edge; readback of addr 5 after reset returns 0xAAAAAAAA.
- Bus-safety assertion, checked in all tests → never (controller driving ram_data && ram_oe=1); req_ready never multi-hot.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared state encoding and default geometry for the single-port RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_ADDR,
        ST_READ_DATA
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: one-hot grant to the first requester after last_grant, with wrap.
// Purely combinational; grant is all-zero when disabled.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_grant_i,
    input  logic           en_i,
    output logic [N-1:0]   grant_o
);

    logic [N-1:0] req_rot;
    logic [N-1:0] gnt_rot;
    int           idx;

    always_comb begin
        req_rot = '0;
        grant_o = '0;
        idx     = 0;
        // Bit k of the rotated vector is the requester k+1 places after the last winner.
        for (int k = 0; k < N; k++) begin
            idx        = (int'(last_grant_i) + 1 + k) % N;
            req_rot[k] = req_i[idx];
        end
        gnt_rot = req_rot & (~req_rot + N'(1));
        for (int k = 0; k < N; k++) begin
            idx          = (int'(last_grant_i) + 1 + k) % N;
            grant_o[idx] = en_i & gnt_rot[k];
        end
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// Round-robin master for one ram_sp: write takes 2 cycles, read returns rsp_valid 3 cycles after accept.
// Backpressure: req_ready is offered only in IDLE, one requester at a time.
module ram_sp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    inout  wire  [DATA_WIDTH-1:0]         ram_data_io,
    output logic                          ram_cs_o,
    output logic                          ram_we_o,
    output logic                          ram_oe_o
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                state_q, state_d;
    logic [IDW-1:0]        last_grant_q, last_grant_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [NUM_REQ-1:0]    grant;
    logic                  grant_en;
    logic [IDW-1:0]        win_id;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  data_drive;

    assign grant_en = rst_n_i && (state_q == ST_IDLE);

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .en_i         (grant_en),
        .grant_o      (grant)
    );

    assign req_ready_o = grant;

    always_comb begin : win_mux
        win_id    = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_id    = IDW'(i);
                win_we    = req_we_i[i];
                win_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin : fsm_comb
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        ram_cs_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_oe_o     = 1'b0;
        data_drive   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    last_grant_d = win_id;
                    id_d         = win_id;
                    addr_d       = win_addr;
                    wdata_d      = win_wdata;
                    state_d      = win_we ? ST_WRITE : ST_READ_ADDR;
                end
            end
            ST_WRITE: begin
                ram_cs_o   = 1'b1;
                ram_we_o   = 1'b1;
                data_drive = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_READ_ADDR: begin
                ram_cs_o = 1'b1;
                ram_oe_o = 1'b1;
                state_d  = ST_READ_DATA;
            end
            ST_READ_DATA: begin
                // The RAM drives the word registered last edge while oe stays high.
                ram_cs_o          = 1'b1;
                ram_oe_o          = 1'b1;
                rsp_valid_d[id_q] = 1'b1;
                rsp_rdata_d       = ram_data_io;
                state_d           = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!rst_n_i) begin
            ram_cs_o   = 1'b0;
            ram_we_o   = 1'b0;
            ram_oe_o   = 1'b0;
            data_drive = 1'b0;
        end
    end

    assign ram_addr_o  = ram_cs_o ? addr_q : '0;
    assign ram_data_io = data_drive ? wdata_q : 'z;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            id_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Randomized scoreboard bench for ram_sp_arbiter with a behavioural ram_sp on the shared bus.
module tb_ram_sp_arbiter;

    localparam int NR    = 2;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req_valid, req_ready, req_we, rsp_valid;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [DW-1:0]      rsp_rdata;
    logic [AW-1:0]      ram_addr;
    wire  [DW-1:0]      ram_data;
    logic               ram_cs, ram_we, ram_oe;

    ram_sp_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .ram_addr_o  (ram_addr),
        .ram_data_io (ram_data),
        .ram_cs_o    (ram_cs),
        .ram_we_o    (ram_we),
        .ram_oe_o    (ram_oe)
    );

    typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
    typedef struct { int id; logic [DW-1:0] data; int due; } exp_t;

    cmd_t          cmd_q0[$];
    cmd_t          cmd_q1[$];
    exp_t          exp_q[$];
    logic [NR-1:0] acc_flags;
    int            n_checks, n_fail, cyc, m_busy;
    bit            gaps;

    // ram_sp: registers a read word at the edge, drives it next cycle while oe holds.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_dout;
    logic          ram_rd_q;
    assign ram_data = (ram_rd_q && ram_oe) ? ram_dout : 'z;

    initial begin
        ram_rd_q = 1'b0;
        ram_dout = '0;
        for (int a = 0; a < DEPTH; a++) ram_mem[a] = '0;
        forever begin
            @(posedge clk);
            if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
            if (ram_cs && !ram_we && ram_oe) begin
                ram_dout <= ram_mem[ram_addr];
                ram_rd_q <= 1'b1;
            end else begin
                ram_rd_q <= 1'b0;
            end
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            automatic int i = (last + k) % NR;
            if (v[i]) return NR'(1) << i;
        end
        return '0;
    endfunction

    function automatic int qsize(input int r);
        return (r == 0) ? cmd_q0.size() : cmd_q1.size();
    endfunction

    function automatic cmd_t head(input int r);
        return (r == 0) ? cmd_q0[0] : cmd_q1[0];
    endfunction

    task automatic push(input int r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c = '{we: we, addr: a, data: d};
        if (r == 0) cmd_q0.push_back(c);
        else        cmd_q1.push_back(c);
    endtask

    // Driver: present each requester's queue head, optionally withdrawing valid at random.
    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        acc_flags = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NR; r++) begin
                if (acc_flags[r]) begin
                    if (r == 0) cmd_q0.delete(0);
                    else        cmd_q1.delete(0);
                    acc_flags[r] = 1'b0;
                end
                if (qsize(r) > 0) begin
                    cmd_t c;
                    c = head(r);
                    req_valid[r]            = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                    req_we[r]               = c.we;
                    req_addr[r*AW +: AW]    = c.addr;
                    req_wdata[r*DW +: DW]   = c.data;
                end else begin
                    req_valid[r] = 1'b0;
                end
            end
        end
    end

    // Monitor + reference model: pin timing, arbitration order, memory contents, responses.
    initial begin
        logic [DW-1:0]   ref_mem [DEPTH];
        logic [DW-1:0]   m_rdata, m_data;
        logic [AW-1:0]   m_addr;
        logic            m_wr, e_drive;
        int              m_last, w;
        bit              armed;
        logic [NR-1:0]   e_ready, acc;
        logic [AW+2:0]   e_pins;
        exp_t            e;
        cmd_t            c;
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        m_busy = 0; m_last = NR - 1; m_rdata = '0; m_data = '0; m_addr = '0;
        m_wr = 1'b0; armed = 1'b0;
        forever begin
            @(negedge clk);
            e_ready = '0;
            e_pins  = '0;
            e_drive = 1'b0;
            if (rst_n) begin
                if (m_busy == 0) begin
                    e_ready = rr_pick(req_valid, m_last);
                end else if (m_wr) begin
                    e_pins  = {3'b110, m_addr};
                    e_drive = 1'b1;
                end else begin
                    e_pins  = {3'b101, m_addr};
                end
            end
            check("req_ready", 64'(req_ready), 64'(e_ready));
            check("ram_pins cs/we/oe/addr", 64'({ram_cs, ram_we, ram_oe, ram_addr}), 64'(e_pins));
            check("bus_drive", 64'(dut.data_drive), 64'(e_drive));
            check("bus_safety drive&oe", 64'(dut.data_drive & ram_oe), 64'(0));
            if (e_drive) check("ram_wdata", 64'(ram_data), 64'(m_data));
            if (armed) begin
                if (rsp_valid != '0) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_id", 64'(rsp_valid), 64'(NR'(1) << e.id));
                        check("rsp_data", 64'(rsp_rdata), 64'(e.data));
                        check("rsp_latency", 64'(cyc), 64'(e.due));
                        m_rdata = e.data;
                    end
                end else begin
                    check("rsp_rdata_hold", 64'(rsp_rdata), 64'(m_rdata));
                    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                        e = exp_q.pop_front();
                        check("rsp_missing", 64'(rsp_valid), 64'(NR'(1) << e.id));
                    end
                end
            end
            if (!rst_n) begin
                m_busy = 0; m_last = NR - 1; m_rdata = '0; armed = 1'b1;
                exp_q.delete();
            end else if (m_busy > 0) begin
                if (m_wr) ref_mem[m_addr] = m_data;
                m_busy--;
            end else begin
                acc = req_valid & req_ready;
                if (acc != '0) begin
                    w = 0;
                    for (int i = NR - 1; i >= 0; i--) if (acc[i]) w = i;
                    c            = head(w);
                    acc_flags[w] = 1'b1;
                    m_last       = w;
                    m_wr         = c.we;
                    m_addr       = c.addr;
                    m_data       = c.data;
                    m_busy       = c.we ? 1 : 2;
                    if (!c.we) exp_q.push_back('{w, ref_mem[c.addr], cyc + 3});
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        bit timed_out;
        n = 0;
        timed_out = 1'b0;
        while ((cmd_q0.size() + cmd_q1.size() + exp_q.size() + m_busy) != 0 && !timed_out) begin
            @(posedge clk);
            n++;
            if (n > 3000) timed_out = 1'b1;
        end
        check(name, 64'(timed_out), 64'(0));
        if (timed_out) begin
            cmd_q0.delete();
            cmd_q1.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int found;
        n_checks = 0;
        n_fail   = 0;
        gaps     = 1'b0;
        rst_n    = 1'b0;

        // Reset with both requesters pending, then write 3 / read 3 across requesters.
        push(0, 1'b1, 4'd3, 32'hDEADBEEF);
        push(1, 1'b0, 4'd3, '0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle("drain_write_read");

        // Contention: interleaved writes, then full readback.
        for (int i = 0; i < 8; i++) begin
            push(0, 1'b1, AW'(2 * i), $urandom);
            push(1, 1'b1, AW'(2 * i + 1), $urandom);
        end
        wait_idle("drain_contention");
        for (int a = 0; a < DEPTH; a++) push(1, 1'b0, AW'(a), '0);
        wait_idle("drain_readback");

        // Fill from requester 0 while requester 1 reads every address.
        for (int a = 0; a < DEPTH; a++) begin
            push(0, 1'b1, AW'(a), $urandom);
            push(1, 1'b0, AW'(a), '0);
        end
        wait_idle("drain_fill");

        // Random mix with valid withdrawn at random.
        gaps = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom);
            push(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom);
        end
        wait_idle("drain_random");
        gaps = 1'b0;

        // Reset while a write is on the pins: old contents must survive.
        push(0, 1'b1, 4'd5, 32'hAAAAAAAA);
        wait_idle("drain_pre_reset");
        push(0, 1'b1, 4'd5, 32'h12345678);
        found = 0;
        for (int n = 0; n < 50 && found == 0; n++) begin
            @(posedge clk);
            #1;
            if (ram_cs && ram_we && ram_addr == 4'd5) found = 1;
        end
        check("reset_write_seen", 64'(found), 64'(1));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(1, 1'b0, 4'd5, '0);
        wait_idle("drain_post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
